// File: rtl/rtc_bus_arbiter_pkg.sv
// rtl/rtc_bus_arbiter_pkg.sv - shared types and requester indices for the RTC bus arbiter
package rtc_bus_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_GAP  = 3'd2,
    ST_DATA = 3'd3,
    ST_REC  = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  localparam int REQ_INIT = 0;
  localparam int REQ_USR  = 1;
  localparam int REQ_POLL = 2;

  function automatic logic [2:0] onehot3(input logic [1:0] idx);
    return 3'b001 << idx;
  endfunction

endpackage

// File: rtl/rtc_bus_arbiter_phase_timer.sv
// rtl/rtc_bus_arbiter_phase_timer.sv - loadable down-counter timing each bus phase
module rtc_bus_arbiter_phase_timer #(
  parameter int CNT_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_value,
  output logic             o_expired
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_value;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/rtc_bus_arbiter.sv
// rtl/rtc_bus_arbiter.sv - arbitrates three requesters onto the multiplexed RTC bus
module rtc_bus_arbiter
  import rtc_bus_arbiter_pkg::*;
#(
  parameter int T_ADDR   = 4,
  parameter int T_GAP    = 2,
  parameter int T_DATA   = 4,
  parameter int T_REC    = 6,
  parameter int MAX_SKIP = 4,
  parameter int CNT_W    = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [2:0]  i_req,
  input  logic [2:0]  i_we,
  input  logic [23:0] i_addr_flat,
  input  logic [23:0] i_wdata_flat,
  output logic [2:0]  o_gnt,
  output logic [2:0]  o_done,
  output logic [7:0]  o_rdata,
  output logic        o_busy,
  output logic        o_cs,
  output logic        o_ad,
  output logic        o_rd,
  output logic        o_wr,
  output logic [7:0]  o_bus_out,
  output logic        o_bus_oe,
  input  logic [7:0]  i_bus_in
);

  localparam int SKIP_W = $clog2(MAX_SKIP + 1);

  state_t            r_state;
  logic [1:0]        r_sel;
  logic              r_we;
  logic [7:0]        r_wdata;
  logic [SKIP_W-1:0] r_skip;
  logic [2:0]        r_gnt, r_done;
  logic [7:0]        r_rdata, r_bus_out;
  logic              r_busy, r_cs, r_ad, r_rd, r_wr, r_bus_oe;

  logic [1:0]        w_idx;
  logic              w_any, w_skip_full, w_load, w_expired;
  logic [7:0]        w_addr, w_wdata;
  logic [CNT_W-1:0]  w_value;

  assign w_skip_full = (r_skip == SKIP_W'(MAX_SKIP));

  // Poll only jumps ahead of user once it has been passed over MAX_SKIP times.
  always_comb begin
    w_any   = |i_req;
    w_idx   = 2'(REQ_POLL);
    w_addr  = i_addr_flat[23:16];
    w_wdata = i_wdata_flat[23:16];
    if (i_req[REQ_INIT])                      w_idx = 2'(REQ_INIT);
    else if (i_req[REQ_POLL] && w_skip_full)  w_idx = 2'(REQ_POLL);
    else if (i_req[REQ_USR])                  w_idx = 2'(REQ_USR);
    case (w_idx)
      2'd0: begin w_addr = i_addr_flat[7:0];  w_wdata = i_wdata_flat[7:0];  end
      2'd1: begin w_addr = i_addr_flat[15:8]; w_wdata = i_wdata_flat[15:8]; end
      default: ;
    endcase
  end

  always_comb begin
    w_load  = 1'b0;
    w_value = '0;
    case (r_state)
      ST_IDLE: if (w_any)     begin w_load = 1'b1; w_value = CNT_W'(T_ADDR - 1); end
      ST_ADDR: if (w_expired) begin w_load = 1'b1; w_value = CNT_W'(T_GAP - 1);  end
      ST_GAP:  if (w_expired) begin w_load = 1'b1; w_value = CNT_W'(T_DATA - 1); end
      ST_DATA: if (w_expired) begin w_load = 1'b1; w_value = CNT_W'(T_REC - 1);  end
      default: ;
    endcase
  end

  rtc_bus_arbiter_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_load    (w_load),
    .i_value   (w_value),
    .o_expired (w_expired)
  );

  // Strobes are set for the state being entered so they change on the same edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;   r_sel <= '0;     r_we <= 1'b0;   r_wdata <= '0;
      r_skip <= '0;         r_gnt <= '0;     r_done <= '0;   r_rdata <= '0;
      r_busy <= 1'b0;       r_cs <= 1'b1;    r_ad <= 1'b1;   r_rd <= 1'b1;
      r_wr <= 1'b1;         r_bus_oe <= 1'b0; r_bus_out <= '0;
    end else begin
      r_done <= '0;
      case (r_state)
        ST_IDLE: if (w_any) begin
          r_state   <= ST_ADDR;
          r_sel     <= w_idx;
          r_we      <= i_we[w_idx];
          r_wdata   <= w_wdata;
          r_gnt     <= onehot3(w_idx);
          r_busy    <= 1'b1;
          r_cs      <= 1'b0;
          r_ad      <= 1'b0;
          r_bus_oe  <= 1'b1;
          r_bus_out <= w_addr;
          if (w_idx == 2'(REQ_POLL))
            r_skip <= '0;
          else if (w_idx == 2'(REQ_USR) && i_req[REQ_POLL] && !w_skip_full)
            r_skip <= r_skip + 1'b1;
        end
        ST_ADDR: if (w_expired) begin
          r_state <= ST_GAP;
          r_ad    <= 1'b1;
        end
        ST_GAP: if (w_expired) begin
          r_state <= ST_DATA;
          if (r_we) begin
            r_wr      <= 1'b0;
            r_bus_out <= r_wdata;
          end else begin
            r_rd      <= 1'b0;
            r_bus_oe  <= 1'b0;
            r_bus_out <= '0;
          end
        end
        ST_DATA: if (w_expired) begin
          r_state <= ST_REC;
          if (!r_we) r_rdata <= i_bus_in;
          r_cs <= 1'b1;  r_rd <= 1'b1;  r_wr <= 1'b1;
          r_bus_oe  <= 1'b0;
          r_bus_out <= '0;
        end
        ST_REC: if (w_expired) begin
          r_state <= ST_DONE;
          r_done  <= onehot3(r_sel);
        end
        default: begin
          r_state <= ST_IDLE;
          r_gnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_gnt     = r_gnt;
  assign o_done    = r_done;
  assign o_rdata   = r_rdata;
  assign o_busy    = r_busy;
  assign o_cs      = r_cs;
  assign o_ad      = r_ad;
  assign o_rd      = r_rd;
  assign o_wr      = r_wr;
  assign o_bus_out = r_bus_out;
  assign o_bus_oe  = r_bus_oe;

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// tb/tb_rtc_bus_arbiter.sv - directed self-checking bench for rtc_bus_arbiter
module tb_rtc_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [2:0]  req = '0, we = '0;
  logic [23:0] addr_flat = '0, wdata_flat = '0;
  logic [2:0]  gnt, done;
  logic [7:0]  rdata, bus_out, bus_in;
  logic        busy, cs, ad, rd, wr, bus_oe;

  int total = 0;
  int bad   = 0;
  bit inject = 1'b0;

  always #5 clk = ~clk;

  // The pad shows 0x37 only while the RTC is being read.
  assign bus_in = rd ? 8'hA5 : 8'h37;

  rtc_bus_arbiter dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_we(we),
    .i_addr_flat(addr_flat), .i_wdata_flat(wdata_flat),
    .o_gnt(gnt), .o_done(done), .o_rdata(rdata), .o_busy(busy),
    .o_cs(cs), .o_ad(ad), .o_rd(rd), .o_wr(wr),
    .o_bus_out(bus_out), .o_bus_oe(bus_oe), .i_bus_in(bus_in)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic serve(input string tag, input logic [2:0] exp_g, input int exp_wait,
                       input logic [7:0] ea, input logic [7:0] ed, input bit is_wr,
                       input logic [2:0] drop);
    int cyc = 0, n = 0, ad_n = 0, rd_n = 0, wr_n = 0, conf = 0, aok = 0, dok = 0;
    logic [2:0] g;
    do begin @(negedge clk); cyc++; end while (gnt == 3'b000 && cyc < 60);
    g = gnt;
    chk({tag, " gnt"}, 32'(g), 32'(exp_g));
    chk({tag, " wait"}, cyc, exp_wait);
    chk({tag, " busy"}, 32'(busy), 32'd1);
    while (n < 40) begin
      n++;
      if (!ad) ad_n++;
      if (!rd) rd_n++;
      if (!wr) wr_n++;
      if ((!rd && !wr) || (bus_oe && !rd)) conf++;
      if (!cs && rd && wr && bus_oe && bus_out == ea) aok++;
      if (!wr && bus_oe && bus_out == ed) dok++;
      if (inject && !rd) req[0] = 1'b1;
      if (done != 3'b000) break;
      @(negedge clk);
    end
    chk({tag, " done"}, 32'(done), 32'(exp_g));
    chk({tag, " len"}, n, 17);
    chk({tag, " ad_low"}, ad_n, 4);
    chk({tag, " rd_low"}, rd_n, is_wr ? 0 : 4);
    chk({tag, " wr_low"}, wr_n, is_wr ? 4 : 0);
    chk({tag, " conflict"}, conf, 0);
    chk({tag, " addr_drv"}, aok, 6);
    chk({tag, " data_drv"}, dok, is_wr ? 4 : 0);
    req = req & ~drop;
  endtask

  initial begin
    int cyc;
    int dn;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst gnt", 32'(gnt), 0);
    chk("rst done", 32'(done), 0);
    chk("rst rdata", 32'(rdata), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst strobes", 32'({cs, ad, rd, wr}), 32'hF);
    chk("rst oe", 32'(bus_oe), 0);
    chk("rst bus_out", 32'(bus_out), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // single poll read
    addr_flat[23:16] = 8'h04;
    req[2] = 1'b1;
    serve("t1", 3'b100, 1, 8'h04, 8'h00, 1'b0, 3'b100);
    chk("t1 rdata", 32'(rdata), 32'h37);
    @(negedge clk);
    chk("t1 done_pulse", 32'(done), 0);
    chk("t1 gnt_clear", 32'(gnt), 0);
    chk("t1 busy_clear", 32'(busy), 0);

    // user write
    addr_flat[15:8] = 8'h21;
    wdata_flat[15:8] = 8'h59;
    we[1] = 1'b1;
    req[1] = 1'b1;
    serve("t2", 3'b010, 1, 8'h21, 8'h59, 1'b1, 3'b010);
    chk("t2 rdata_hold", 32'(rdata), 32'h37);

    // all three at once
    we = 3'b000;
    addr_flat = {8'h30, 8'h20, 8'h10};
    req = 3'b111;
    serve("t3i", 3'b001, 2, 8'h10, 8'h00, 1'b0, 3'b001);
    serve("t3u", 3'b010, 2, 8'h20, 8'h00, 1'b0, 3'b010);
    serve("t3p", 3'b100, 2, 8'h30, 8'h00, 1'b0, 3'b100);

    // user hogging: poll wins after four user grants
    req = 3'b110;
    for (int i = 0; i < 4; i++)
      serve("t4u", 3'b010, 2, 8'h20, 8'h00, 1'b0, 3'b000);
    serve("t4p", 3'b100, 2, 8'h30, 8'h00, 1'b0, 3'b110);

    // init arrives mid-poll: no preemption
    inject = 1'b1;
    req[2] = 1'b1;
    serve("t5p", 3'b100, 2, 8'h30, 8'h00, 1'b0, 3'b100);
    inject = 1'b0;
    chk("t5 rdata", 32'(rdata), 32'h37);
    serve("t5i", 3'b001, 2, 8'h10, 8'h00, 1'b0, 3'b001);

    // reset during GAP
    we[1] = 1'b1;
    req[1] = 1'b1;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!(gnt[1] && !cs && ad) && cyc < 60);
    chk("t6 gap_seen", 32'(cyc < 60), 1);
    rst_n = 1'b0;
    req = '0;
    #1;
    chk("t6 strobes", 32'({cs, ad, rd, wr}), 32'hF);
    chk("t6 oe", 32'(bus_oe), 0);
    chk("t6 gnt", 32'(gnt), 0);
    chk("t6 busy", 32'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done != 3'b000) dn++;
    end
    chk("t6 no_done", dn, 0);
    chk("t6 rdata", 32'(rdata), 0);
    chk("t6 idle", 32'({busy, gnt}), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
